mux32_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one N-bit output channel among 32 requesters.

---
 rtl/mux32_rr_arbiter.sv | 110 +++++++++++
 tb/tb_mux32_rr_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mux32_rr_arbiter.sv
// Round-robin arbiter: 32 requesters share one N-bit valid/ready channel through an internal mux32.
// Optional MUX32_ARB_LOCK_EN adds a lock input that keeps the grant on sel for bursts.

module mux32 #(
    parameter int N = 8
) (
    input  logic [32*N-1:0] in_data,
    input  logic [4:0]      sel,
    output logic [N-1:0]    out_data
);
    assign out_data = in_data[int'(sel)*N +: N];
endmodule

module mux32_rr_arbiter #(
    parameter int N = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     req,
    input  logic [32*N-1:0] in_data,
`ifdef MUX32_ARB_LOCK_EN
    input  logic            lock,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_data,
    output logic [4:0]      sel,
    output logic [31:0]     ack,
    output logic            busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t      state, state_n;
    logic [4:0]  ptr, ptr_n, sel_n;
    logic [31:0] sel_bit, others;
    logic        hold_lock;

    // First set bit of mask searching start, start+1, ... wrapping mod 32.
    function automatic logic [4:0] rr_pick(input logic [31:0] mask, input logic [4:0] start);
        logic [31:0] rot;
        logic [4:0]  idx;
        logic        found;
        rot   = 32'({mask, mask} >> start);
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (!found && rot[i]) begin
                idx   = 5'(i);
                found = 1'b1;
            end
        end
        return start + idx;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
            ptr   <= '0;
        end else begin
            state <= state_n;
            sel   <= sel_n;
            ptr   <= ptr_n;
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = sel;
        ptr_n   = ptr;
        ack     = '0;
        sel_bit = 32'd1 << sel;
        others  = req & ~sel_bit;
`ifdef MUX32_ARB_LOCK_EN
        hold_lock = lock && req[sel];
`else
        hold_lock = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (|req) begin
                    sel_n   = rr_pick(req, ptr);
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (out_ready) begin
                    // A reset in the handshake cycle drops the word, so no ack escapes.
                    ack = rst ? '0 : sel_bit;
                    if (!hold_lock) begin
                        ptr_n = sel + 5'd1;
                        if (|others) sel_n = rr_pick(others, sel + 5'd1);
                        else         state_n = IDLE;
                    end
                end
            end
        endcase
    end

    assign out_valid = (state == GRANT);
    assign busy      = out_valid;

    mux32 #(.N(N)) u_mux (
        .in_data  (in_data),
        .sel      (sel),
        .out_data (out_data)
    );

endmodule

// File: tb/tb_mux32_rr_arbiter.sv
// Directed bench for mux32_rr_arbiter (N=8, requester k drives data k+1); lock scenario runs with MUX32_ARB_LOCK_EN.

module tb_mux32_rr_arbiter;
    localparam int N = 8;

    logic            clk;
    logic            rst;
    logic [31:0]     req;
    logic [32*N-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    out_data;
    logic [4:0]      sel;
    logic [31:0]     ack;
    logic            busy;
`ifdef MUX32_ARB_LOCK_EN
    logic            lock;
`endif

    int checks;
    int failures;

    mux32_rr_arbiter #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in_data   (in_data),
`ifdef MUX32_ARB_LOCK_EN
        .lock      (lock),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sel       (sel),
        .ack       (ack),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 32'hFFFF_FFFF; out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_valid cyc%0d got=%b/%b exp=0", c, out_valid, busy); end
            checks++;
            if (sel !== 5'd0) begin failures++; $display("FAIL reset_sel cyc%0d got=%0d exp=0", c, sel); end
            checks++;
            if (ack !== 32'h0) begin failures++; $display("FAIL reset_ack cyc%0d got=%h exp=0", c, ack); end
        end
        @(negedge clk);
        rst = 1'b0; req = '0; out_ready = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        req = 32'h0000_0010; out_ready = 1'b1; #1;
        checks++;
        if (out_valid !== 1'b0 || ack !== 32'h0) begin failures++; $display("FAIL idle_ready got valid=%b ack=%h exp valid=0 ack=0", out_valid, ack); end
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || sel !== 5'd4 || out_data !== 8'd5 || ack !== 32'h10)
            begin failures++; $display("FAIL single_grant got v=%b sel=%0d data=%0d ack=%h exp v=1 sel=4 data=5 ack=10", out_valid, sel, out_data, ack); end
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || ack !== 32'h0) begin failures++; $display("FAIL single_after got v=%b ack=%h exp v=0 ack=0", out_valid, ack); end
        @(negedge clk);
        req = 32'h0; #1;
        checks++;
        if (out_valid !== 1'b1 || sel !== 5'd4 || ack !== 32'h10)
            begin failures++; $display("FAIL single_regrant got v=%b sel=%0d ack=%h exp v=1 sel=4 ack=10", out_valid, sel, ack); end
        @(negedge clk);
        out_ready = 1'b0; #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL single_idle got v=%b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] seen;
        int          dups;
        logic [4:0]  k;
        seen = '0; dups = 0;
        do_reset();
        req = 32'hFFFF_FFFF; out_ready = 1'b1;
        for (int i = 0; i < 33; i++) begin
            @(negedge clk); #1;
            k = 5'(i % 32);
            checks++;
            if (out_valid !== 1'b1 || sel !== k || out_data !== 8'(k + 1) || ack !== (32'd1 << k))
                begin failures++; $display("FAIL rr_step%0d got v=%b sel=%0d data=%0d ack=%h exp sel=%0d data=%0d", i, out_valid, sel, out_data, ack, k, k + 1); end
            if (i < 32) begin
                if ((seen & ack) != 0 || $countones(ack) != 1) dups++;
                seen = seen | ack;
            end
        end
        checks++;
        if (seen !== 32'hFFFF_FFFF || dups != 0) begin failures++; $display("FAIL rr_fair got seen=%h dups=%0d exp seen=ffffffff dups=0", seen, dups); end
        @(negedge clk);
        req = 32'h0;
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rr_drain got v=%b exp 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_wrap_hold();
        do_reset();
        req = 32'h0000_0001; out_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (sel !== 5'd0 || ack !== 32'h1) begin failures++; $display("FAIL wrap_prep got sel=%0d ack=%h exp sel=0 ack=1", sel, ack); end
        @(negedge clk);
        req = 32'h8000_0001; out_ready = 1'b0; #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL wrap_idle got v=%b exp 0", out_valid); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || sel !== 5'd31 || out_data !== 8'd32 || ack !== 32'h0)
                begin failures++; $display("FAIL wrap_hold%0d got v=%b sel=%0d data=%0d ack=%h exp v=1 sel=31 data=32 ack=0", c, out_valid, sel, out_data, ack); end
        end
        @(negedge clk);
        out_ready = 1'b1; #1;
        checks++;
        if (ack !== 32'h8000_0000) begin failures++; $display("FAIL wrap_ack got=%h exp=80000000", ack); end
        @(negedge clk);
        req = 32'h0; #1;
        checks++;
        if (out_valid !== 1'b1 || sel !== 5'd0 || out_data !== 8'd1 || ack !== 32'h1)
            begin failures++; $display("FAIL wrap_next got v=%b sel=%0d data=%0d ack=%h exp v=1 sel=0 data=1 ack=1", out_valid, sel, out_data, ack); end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 32'h0000_0080; out_ready = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || sel !== 5'd7) begin failures++; $display("FAIL mid_grant got v=%b sel=%0d exp v=1 sel=7", out_valid, sel); end
        @(negedge clk);
        rst = 1'b1; out_ready = 1'b1; #1;
        checks++;
        if (ack !== 32'h0) begin failures++; $display("FAIL mid_rst_ack got=%h exp=0", ack); end
        @(negedge clk);
        rst = 1'b0; req = 32'h0000_0081; out_ready = 1'b0; #1;
        checks++;
        if (out_valid !== 1'b0 || sel !== 5'd0 || ack !== 32'h0)
            begin failures++; $display("FAIL mid_after got v=%b sel=%0d ack=%h exp v=0 sel=0 ack=0", out_valid, sel, ack); end
        @(negedge clk);
        out_ready = 1'b1; #1;
        checks++;
        if (out_valid !== 1'b1 || sel !== 5'd0 || out_data !== 8'd1 || ack !== 32'h1)
            begin failures++; $display("FAIL mid_restart got v=%b sel=%0d data=%0d ack=%h exp v=1 sel=0 data=1 ack=1", out_valid, sel, out_data, ack); end
        @(negedge clk); #1;
        checks++;
        if (sel !== 5'd7 || out_data !== 8'd8 || ack !== 32'h80)
            begin failures++; $display("FAIL mid_second got sel=%0d data=%0d ack=%h exp sel=7 data=8 ack=80", sel, out_data, ack); end
        @(negedge clk);
        req = 32'h0;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

`ifdef MUX32_ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        req = 32'h0000_0006; lock = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || sel !== 5'd1 || out_data !== 8'd2 || ack !== 32'h2)
                begin failures++; $display("FAIL lock_burst%0d got v=%b sel=%0d data=%0d ack=%h exp sel=1 data=2 ack=2", i, out_valid, sel, out_data, ack); end
        end
        @(negedge clk);
        lock = 1'b0; #1;
        checks++;
        if (sel !== 5'd1 || ack !== 32'h2) begin failures++; $display("FAIL lock_release got sel=%0d ack=%h exp sel=1 ack=2", sel, ack); end
        @(negedge clk); #1;
        checks++;
        if (sel !== 5'd2 || out_data !== 8'd3 || ack !== 32'h4)
            begin failures++; $display("FAIL lock_next got sel=%0d data=%0d ack=%h exp sel=2 data=3 ack=4", sel, out_data, ack); end
        req = 32'h0;
        @(negedge clk);
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        checks = 0; failures = 0;
        for (int k = 0; k < 32; k++) in_data[k*N +: N] = 8'(k + 1);
`ifdef MUX32_ARB_LOCK_EN
        lock = 1'b0;
`endif
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap_hold();
        test_reset_mid_grant();
`ifdef MUX32_ARB_LOCK_EN
        test_lock();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
